booth_dot_accumulator: RTL and testbench
========================================

Name: booth_dot_accumulator

Overview:
- Downstream consumer of the booth multiplier's product/done pair.
- Sign-extends and sums K consecutive products into one dot-product result, with per-add saturation.
- Completed results are buffered in a 2-deep FIFO and presented on a valid/ready interface.
- The multiplier cannot be back-pressured, so results that find the FIFO full are dropped and flagged.

Parameters:
- N, 8: operand width of the upstream multiplier; products are 2*N bits.
- K, 4: number of products per dot product; K >= 1.
- ACC_W, 18: accumulator and result width; ACC_W >= 2*N.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- prod_valid  input  1  one-cycle pulse; prod_data is valid (driven by the multiplier's done).
- prod_data  input  2*N  product, two's complement signed.
- clear  input  1  synchronous flush of the partial accumulation.
- acc_valid  output  1  FIFO head holds a result.
- acc_ready  input  1  consumer accepts the head this cycle.
- acc_data  output  ACC_W  dot-product result at the FIFO head.
- acc_sat  output  1  head result saturated at least once during its accumulation.
- term_cnt  output  clog2(K)+1  products accumulated in the current dot product.
- err_drop  output  1  sticky: a completed result was lost to a full FIFO.

Behaviour:
Reset:
- rst asynchronous and active-high; effective immediately, including mid-accumulation.
- Clears accumulator, term_cnt, sat_run, FIFO, err_drop. Outputs: acc_valid=0, acc_data=0, acc_sat=0, term_cnt=0, err_drop=0.

Accumulation:
- Each cycle with prod_valid=1 and clear=0: sum = acc + sext(prod_data) computed at ACC_W+1 bits.
- Signed overflow saturates to +max (0 followed by ones) or -min (1 followed by zeros) and sets sat_run. Otherwise acc <= sum.
- term_cnt increments by 1.

Completion:
- A product arriving with term_cnt == K-1 completes the dot product.
- The saturated sum and the saturation flag (sat_run OR saturation on this add) are pushed into the FIFO.
- acc, term_cnt and sat_run return to 0 in the same cycle.
- Latency: completing prod_valid in cycle t gives acc_valid=1 in cycle t+1 when the FIFO was empty.

clear:
- Zeroes acc, term_cnt and sat_run. FIFO and err_drop are untouched.
- clear together with prod_valid: clear wins and the product is discarded.

Output handshake:
- A pop occurs when acc_valid && acc_ready.
- acc_data and acc_sat stay stable while acc_valid=1 and acc_ready=0.
- Order is FIFO.

FIFO boundaries:
- Full with no pop at completion: result discarded, err_drop <= 1. Accumulator still resets.
- Full with pop in the same cycle: push is accepted.
- Empty: acc_ready is ignored.
- err_drop clears only on rst.

Control FSM (two states):
- ACCUM: term_cnt > 0.
- IDLE: term_cnt == 0.
- IDLE -> ACCUM on an accepted prod_valid when K > 1.
- ACCUM -> IDLE on completion or clear.
- When K == 1, every product completes immediately and the FSM stays IDLE.

Width rules:
- Products are always sign-extended to ACC_W.
- No rounding or truncation is applied.

Decomposition:
- Shared package: a clog2 function; the saturation constants (SAT_MAX, SAT_MIN as functions of ACC_W); the FIFO entry layout {sat, data}.
- One sub-module: booth_result_fifo, a synchronous 2-entry FIFO of width ACC_W+1 with push/pop/full/empty and the same clk/rst.
- The accumulator and FSM live in the top module.

Test Plan:
- Basic sum (defaults): prod_data 3, 5, 7, 9 on 4 pulses, acc_ready=1 -> acc_valid one cycle after the 4th pulse, acc_data=24, acc_sat=0, term_cnt back to 0.
- Negative products: four pulses of 0xFFFF (-1) -> acc_data=0x3FFFC (-4), acc_sat=0.
- Back-pressure and drop: acc_ready=0, three dot products of four 1s each -> FIFO holds 4, 4. The third result is dropped and err_drop=1. Raising acc_ready drains 4 then 4, then acc_valid=0.
- Saturation (ACC_W=16): four pulses of 0x7FFF -> acc_data=0x7FFF, acc_sat=1. Next dot product of 1, 1, 1, 1 -> acc_data=4, acc_sat=0.
- clear mid-operation: products 10, 20, then clear, then 1, 1, 1, 1 -> single result acc_data=4.
- clear with prod_valid in the same cycle: that product is not counted (term_cnt unchanged after flush = 0).
- Reset mid-operation: assert rst after 2 products with one result queued -> next cycle acc_valid=0, term_cnt=0, err_drop=0. A subsequent 2, 2, 2, 2 gives acc_data=8.

Source files
------------

// File: rtl/booth_dot_accumulator_pkg.sv
// Shared definitions for the booth dot-product accumulator: sizing helpers,
// saturation constants and the layout of one buffered result entry.
package booth_dot_accumulator_pkg;

  // Width of the constant words returned by the saturation helpers; callers
  // keep the low ACC_W bits.
  localparam int SAT_CONST_W = 64;

  // Control FSM: IDLE while no product of the current dot product has been
  // taken, ACCUM while a partial sum is in flight.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Largest positive two's complement value of acc_w bits (0 then ones).
  function automatic logic [SAT_CONST_W-1:0] sat_max(input int acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of acc_w bits (1 then zeros).
  function automatic logic [SAT_CONST_W-1:0] sat_min(input int acc_w);
    return 64'd1 << (acc_w - 1);
  endfunction

  // FIFO entry layout is {sat, data}: data in [acc_w-1:0], sat flag on top.
  function automatic int entry_w(input int acc_w);
    return acc_w + 1;
  endfunction

  function automatic int entry_sat_bit(input int acc_w);
    return acc_w;
  endfunction

endpackage

// File: rtl/booth_dot_accumulator_if.sv
// Product stream in, dot-product result stream out, plus status.
// The accumulator takes the slave view; the driver/consumer takes master.
interface booth_dot_accumulator_if
  import booth_dot_accumulator_pkg::*;
#(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int ACC_W = 18
);
  localparam int TC_W = clog2(K) + 1;

  logic              prod_valid;
  logic [2*N-1:0]    prod_data;
  logic              clear;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic              acc_sat;
  logic [TC_W-1:0]   term_cnt;
  logic              err_drop;

  modport slave (
    input  prod_valid, prod_data, clear, acc_ready,
    output acc_valid, acc_data, acc_sat, term_cnt, err_drop
  );

  modport master (
    output prod_valid, prod_data, clear, acc_ready,
    input  acc_valid, acc_data, acc_sat, term_cnt, err_drop
  );
endinterface

// File: rtl/booth_result_fifo.sv
// Two-entry synchronous FIFO for completed dot-product results.
// A push into a full FIFO is taken only when a pop happens in the same cycle;
// a pop from an empty FIFO is ignored.
module booth_result_fifo #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s, do_pop_s;

  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums K consecutive signed products from the booth multiplier into one
// saturating dot product and queues finished results in a 2-deep FIFO.
// The multiplier cannot stall, so a result meeting a full FIFO is dropped
// and the sticky err_drop flag is raised.
module booth_dot_accumulator
  import booth_dot_accumulator_pkg::*;
#(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int ACC_W = 18
) (
  input logic                    clk,
  input logic                    rst,
  booth_dot_accumulator_if.slave bus
);
  localparam int TC_W    = clog2(K) + 1;
  localparam int EW      = entry_w(ACC_W);
  localparam int SAT_BIT = entry_sat_bit(ACC_W);
  localparam logic [SAT_CONST_W-1:0] SAT_MAX_WIDE = sat_max(ACC_W);
  localparam logic [SAT_CONST_W-1:0] SAT_MIN_WIDE = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX   = SAT_MAX_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN   = SAT_MIN_WIDE[ACC_W-1:0];
  localparam logic [TC_W-1:0]  LAST_TERM = TC_W'(K - 1);

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TC_W-1:0]   term_cnt_q, term_cnt_d;
  logic              sat_run_q, sat_run_d;
  logic              err_drop_q, err_drop_d;

  logic [ACC_W:0]    prod_x_s;
  logic [ACC_W:0]    sum_s;
  logic              ovf_s;
  logic [ACC_W-1:0]  sat_sum_s;
  logic              accept_s, complete_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              push_s, pop_s, drop_s;
  logic [EW-1:0]     push_entry_s, head_entry_s;

  // ACC_W >= 2*N, so at least one sign bit is replicated here.
  assign prod_x_s = {{(ACC_W + 1 - 2*N){bus.prod_data[2*N-1]}}, bus.prod_data};

  // Saturating add: overflow shows as the two top bits of the wide sum disagreeing.
  always_comb begin
    sum_s = {acc_q[ACC_W-1], acc_q} + prod_x_s;
    ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (ovf_s) begin
      if (sum_s[ACC_W]) begin
        sat_sum_s = SAT_MIN;
      end else begin
        sat_sum_s = SAT_MAX;
      end
    end else begin
      sat_sum_s = sum_s[ACC_W-1:0];
    end
  end

  // clear beats a simultaneous product, which is then discarded.
  assign accept_s     = bus.prod_valid & ~bus.clear;
  assign complete_s   = accept_s & (term_cnt_q == LAST_TERM);
  assign pop_s        = bus.acc_ready & ~fifo_empty_s;
  assign push_s       = complete_s & (~fifo_full_s | pop_s);
  assign drop_s       = complete_s & fifo_full_s & ~pop_s;
  assign push_entry_s = {sat_run_q | ovf_s, sat_sum_s};

  // FSM next state plus accumulator, term counter, saturation and drop flags.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    term_cnt_d = term_cnt_q;
    sat_run_d  = sat_run_q;
    err_drop_d = err_drop_q | drop_s;

    case (state_q)
      ST_IDLE: begin
        if (accept_s && !complete_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.clear || complete_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clear || complete_s) begin
      acc_d      = '0;
      term_cnt_d = '0;
      sat_run_d  = 1'b0;
    end else if (accept_s) begin
      acc_d      = sat_sum_s;
      term_cnt_d = term_cnt_q + TC_W'(1);
      sat_run_d  = sat_run_q | ovf_s;
    end else begin
      acc_d      = acc_q;
      term_cnt_d = term_cnt_q;
      sat_run_d  = sat_run_q;
    end
  end

  // Accumulator and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      term_cnt_q <= '0;
      sat_run_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      term_cnt_q <= term_cnt_d;
      sat_run_q  <= sat_run_d;
      err_drop_q <= err_drop_d;
    end
  end

  booth_result_fifo #(
    .W (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_entry_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign bus.acc_valid = ~fifo_empty_s;
  assign bus.acc_data  = head_entry_s[ACC_W-1:0];
  assign bus.acc_sat   = head_entry_s[SAT_BIT];
  assign bus.term_cnt  = term_cnt_q;
  assign bus.err_drop  = err_drop_q;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Self-checking bench for booth_dot_accumulator: a default 18-bit instance
// and a 16-bit instance that can reach saturation.
module tb_booth_dot_accumulator;
  import booth_dot_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_dot_accumulator_if #(.N(8), .K(4), .ACC_W(18)) b0 ();
  booth_dot_accumulator_if #(.N(8), .K(4), .ACC_W(16)) b1 ();

  booth_dot_accumulator #(.N(8), .K(4), .ACC_W(18)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  booth_dot_accumulator #(.N(8), .K(4), .ACC_W(16)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  typedef struct packed {
    logic [17:0] data;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [15:0] p [4];
    logic [17:0] data;
    logic        sat;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe pops at the falling edge, then advance past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (b0.acc_valid && b0.acc_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop0: got 0x%0h expected no result", b0.acc_data);
      end else begin
        e = q0.pop_front();
        chk("data0", 32'(b0.acc_data), 32'(e.data));
        chk("sat0", 32'(b0.acc_sat), 32'(e.sat));
      end
    end
    if (b1.acc_valid && b1.acc_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop1: got 0x%0h expected no result", b1.acc_data);
      end else begin
        e = q1.pop_front();
        chk("data1", 32'(b1.acc_data), 32'(e.data));
        chk("sat1", 32'(b1.acc_sat), 32'(e.sat));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic prod0(input logic [15:0] v);
    b0.prod_valid = 1'b1;
    b0.prod_data  = v;
    cycle();
    b0.prod_valid = 1'b0;
  endtask

  task automatic prod1(input logic [15:0] v);
    b1.prod_valid = 1'b1;
    b1.prod_data  = v;
    cycle();
    b1.prod_valid = 1'b0;
  endtask

  task automatic dp0(input logic [15:0] v);
    for (int j = 0; j < 4; j++) prod0(v);
  endtask

  task automatic dp1(input logic [15:0] v);
    for (int j = 0; j < 4; j++) prod1(v);
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && (q0.size() > 0 || q1.size() > 0); i++) cycle();
    chk({name, "_q0_left"}, 32'(q0.size()), 32'd0);
    chk({name, "_q1_left"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{p: '{16'd3, 16'd5, 16'd7, 16'd9},             data: 18'd24,     sat: 1'b0};
    vecs[1] = '{p: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, data: 18'h3FFFC,  sat: 1'b0};
    vecs[2] = '{p: '{16'd100, 16'hFFCE, 16'd7, 16'hFED4},     data: 18'h3FF0D,  sat: 1'b0};
    vecs[3] = '{p: '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, data: 18'h1FFFC,  sat: 1'b0};
    vecs[4] = '{p: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, data: 18'h20000,  sat: 1'b0};

    rst = 1'b1;
    b0.prod_valid = 1'b0; b0.prod_data = 16'd0; b0.clear = 1'b0; b0.acc_ready = 1'b0;
    b1.prod_valid = 1'b0; b1.prod_data = 16'd0; b1.clear = 1'b0; b1.acc_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_acc_valid", 32'(b0.acc_valid), 32'd0);
    chk("rst_acc_data", 32'(b0.acc_data), 32'd0);
    chk("rst_acc_sat", 32'(b0.acc_sat), 32'd0);
    chk("rst_term_cnt", 32'(b0.term_cnt), 32'd0);
    chk("rst_err_drop", 32'(b0.err_drop), 32'd0);
    rst = 1'b0;
    cycle();

    // Table of dot products with the consumer always ready.
    b0.acc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) q0.push_back('{data: vecs[i].data, sat: vecs[i].sat});
        prod0(vecs[i].p[j]);
        if (j == 1) chk("vec_term_mid", 32'(b0.term_cnt), 32'd2);
      end
      chk("vec_latency_valid", 32'(b0.acc_valid), 32'd1);
      chk("vec_term_done", 32'(b0.term_cnt), 32'd0);
    end
    drain("vec", 10);

    // Full FIFO with a pop in the completing cycle: push still taken.
    b0.acc_ready = 1'b0;
    q0.push_back('{data: 18'd4, sat: 1'b0});
    dp0(16'd1);
    q0.push_back('{data: 18'd8, sat: 1'b0});
    dp0(16'd2);
    chk("full_head_data", 32'(b0.acc_data), 32'd4);
    for (int j = 0; j < 3; j++) prod0(16'd3);
    b0.acc_ready = 1'b1;
    q0.push_back('{data: 18'd12, sat: 1'b0});
    prod0(16'd3);
    chk("popfull_err_drop", 32'(b0.err_drop), 32'd0);
    drain("popfull", 10);
    chk("popfull_empty", 32'(b0.acc_valid), 32'd0);

    // Back-pressure: third result finds the FIFO full and is dropped.
    b0.acc_ready = 1'b0;
    q0.push_back('{data: 18'd4, sat: 1'b0});
    q0.push_back('{data: 18'd4, sat: 1'b0});
    dp0(16'd1);
    dp0(16'd1);
    chk("drop_err_before", 32'(b0.err_drop), 32'd0);
    dp0(16'd1);
    chk("drop_err_drop", 32'(b0.err_drop), 32'd1);
    chk("drop_term_cnt", 32'(b0.term_cnt), 32'd0);
    cycle(); cycle();
    chk("hold_valid", 32'(b0.acc_valid), 32'd1);
    chk("hold_data", 32'(b0.acc_data), 32'd4);
    b0.acc_ready = 1'b1;
    drain("drop", 10);
    chk("drop_empty", 32'(b0.acc_valid), 32'd0);
    cycle();
    chk("empty_ready_ignored", 32'(b0.acc_valid), 32'd0);

    // clear mid-accumulation.
    prod0(16'd10);
    prod0(16'd20);
    chk("clr_term_before", 32'(b0.term_cnt), 32'd2);
    b0.clear = 1'b1;
    cycle();
    b0.clear = 1'b0;
    chk("clr_term_after", 32'(b0.term_cnt), 32'd0);
    chk("clr_no_result", 32'(b0.acc_valid), 32'd0);
    q0.push_back('{data: 18'd4, sat: 1'b0});
    dp0(16'd1);
    drain("clr", 10);

    // clear and prod_valid together: the product is discarded.
    prod0(16'd7);
    chk("clrpv_term_before", 32'(b0.term_cnt), 32'd1);
    b0.clear = 1'b1;
    b0.prod_valid = 1'b1;
    b0.prod_data = 16'd50;
    cycle();
    b0.clear = 1'b0;
    b0.prod_valid = 1'b0;
    chk("clrpv_term_after", 32'(b0.term_cnt), 32'd0);
    q0.push_back('{data: 18'd4, sat: 1'b0});
    dp0(16'd1);
    drain("clrpv", 10);

    // Saturation on the 16-bit instance, both directions, then a clean result.
    q1.push_back('{data: 18'h07FFF, sat: 1'b1});
    dp1(16'h7FFF);
    q1.push_back('{data: 18'h00004, sat: 1'b0});
    dp1(16'd1);
    q1.push_back('{data: 18'h08000, sat: 1'b1});
    dp1(16'h8000);
    drain("sat", 10);

    // Reset in the middle of an accumulation with a result queued.
    b0.acc_ready = 1'b0;
    dp0(16'd5);
    q0.push_back('{data: 18'd4, sat: 1'b0});
    q0.push_back('{data: 18'd4, sat: 1'b0});
    dp0(16'd1);
    dp0(16'd1);
    void'(q0.pop_back());
    void'(q0.pop_back());
    chk("pre_rst_err_drop", 32'(b0.err_drop), 32'd1);
    prod0(16'd2);
    prod0(16'd2);
    chk("pre_rst_term", 32'(b0.term_cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b0.acc_valid), 32'd0);
    cycle();
    chk("rst_mid_valid", 32'(b0.acc_valid), 32'd0);
    chk("rst_mid_term", 32'(b0.term_cnt), 32'd0);
    chk("rst_mid_err_drop", 32'(b0.err_drop), 32'd0);
    rst = 1'b0;
    b0.acc_ready = 1'b1;
    cycle();
    q0.push_back('{data: 18'd8, sat: 1'b0});
    dp0(16'd2);
    drain("post_rst", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
